// File: rtl/branch_cmp_serial_if.sv
// Request/response bundle for branch_cmp_serial.
// Request side:  i_valid/o_ready handshake carrying i_rs1, i_rs2, i_funct3.
// Response side: o_valid/i_ready handshake carrying o_equal, o_less, o_taken,
//                o_illegal.
// slave  : comparator view (consumes requests, produces results).
// master : requester/consumer view.
interface branch_cmp_serial_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [2:0]      i_funct3;
  logic            o_valid;
  logic            i_ready;
  logic            o_equal;
  logic            o_less;
  logic            o_taken;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_funct3, i_ready,
    output o_ready, o_valid, o_equal, o_less, o_taken, o_illegal
  );

  modport master (
    output i_valid, i_rs1, i_rs2, i_funct3, i_ready,
    input  o_ready, o_valid, o_equal, o_less, o_taken, o_illegal
  );
endinterface

// File: rtl/branch_cmp_serial.sv
// Multi-cycle RV32I branch comparator.
// Compares DIGIT bits per cycle, LSB-first; a differing higher digit overrides
// the verdict of lower digits. Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : branch_cmp_serial_if.slave (request and response handshakes)
module branch_cmp_serial #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  branch_cmp_serial_if.slave bus
);
  localparam int NDIG = XLEN / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (XLEN % DIGIT != 0) begin : g_bad_digit
      $error("branch_cmp_serial: XLEN must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      f3_q;
  logic [CW-1:0]   cnt;
  logic            eq_q, lt_q;
  logic            equal_q, less_q, taken_q, illegal_q;

  logic             ready, valid, accept, last;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             eq_n, lt_n, taken_n;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    valid   = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = bus.i_valid;
        if (bus.i_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (bus.i_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands shift right by one digit per RUN cycle, so the digit under test is
  // always the low digit and the final digit's top bit is the original sign bit.
  always_comb begin
    last  = (cnt == LAST);
    a_dig = a_q[DIGIT-1:0];
    b_dig = b_q[DIGIT-1:0];
    eq_n  = eq_q;
    lt_n  = lt_q;
    if (a_dig != b_dig) begin
      eq_n = 1'b0;
      lt_n = (a_dig < b_dig);
    end
    // Signed mode: differing sign bits decide the result outright.
    if (last && !f3_q[1] && (a_dig[DIGIT-1] != b_dig[DIGIT-1]))
      lt_n = a_dig[DIGIT-1];
    case (f3_q)
      3'b000:          taken_n = eq_n;
      3'b001:          taken_n = !eq_n;
      3'b100, 3'b110:  taken_n = lt_n;
      3'b101, 3'b111:  taken_n = !lt_n;
      default:         taken_n = 1'b0;
    endcase
  end

  // Datapath; result registers load on the last digit so they hold through
  // DONE and the following IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      cnt       <= '0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      equal_q   <= 1'b0;
      less_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      a_q  <= bus.i_rs1;
      b_q  <= bus.i_rs2;
      f3_q <= bus.i_funct3;
      cnt  <= '0;
      eq_q <= 1'b1;
      lt_q <= 1'b0;
    end else if (state == RUN) begin
      a_q  <= a_q >> DIGIT;
      b_q  <= b_q >> DIGIT;
      cnt  <= cnt + 1'b1;
      eq_q <= eq_n;
      lt_q <= lt_n;
      if (last) begin
        equal_q   <= eq_n;
        less_q    <= lt_n;
        taken_q   <= taken_n;
        illegal_q <= (f3_q[2:1] == 2'b01);
      end
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = valid;
  assign bus.o_equal   = equal_q;
  assign bus.o_less    = less_q;
  assign bus.o_taken   = taken_q;
  assign bus.o_illegal = illegal_q;
endmodule
